// File: rtl/inport_packet_requester_if.sv
// Signal bundle between one input-port requester and its FIFO, arbiter and crossbar.
`ifndef FLIT_BitWidth
`define FLIT_BitWidth 32
`endif

interface inport_packet_requester_if #(
    parameter int unsigned FLIT_W = `FLIT_BitWidth
);
    logic              fifo_empty;
    logic [FLIT_W-1:0] fifo_dout;
    logic              fifo_rd;
    logic              req;
    logic [FLIT_W-1:0] head_flit;
    logic              grant;
    logic              locked;
    logic              xbar_valid;
    logic [FLIT_W-1:0] xbar_flit;
    logic              xbar_ready;
    logic              pkt_done;

    // Requester side
    modport master (
        input  fifo_empty, fifo_dout, grant, xbar_ready,
        output fifo_rd, req, head_flit, locked, xbar_valid, xbar_flit, pkt_done
    );

    // FIFO / arbiter / crossbar side
    modport slave (
        output fifo_empty, fifo_dout, grant, xbar_ready,
        input  fifo_rd, req, head_flit, locked, xbar_valid, xbar_flit, pkt_done
    );
endinterface

// File: rtl/inport_packet_requester.sv
// Pops a packet head, requests the arbiter, then streams head and body flits
// into the crossbar under a valid/ready handshake.
`ifndef FLIT_BitWidth
`define FLIT_BitWidth 32
`endif

module inport_packet_requester #(
    parameter int unsigned FLIT_W    = `FLIT_BitWidth,
    parameter int unsigned PKT_FLITS = 4
) (
    input logic clk,
    input logic rst,
    inport_packet_requester_if.master bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_FLITS - 1);

    typedef enum logic [1:0] {IDLE, REQ, HEAD, BODY} state_t;

    state_t            state_q, state_d;
    logic [FLIT_W-1:0] head_q, head_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              fifo_rd_c;
    logic              req_c;
    logic              locked_c;
    logic              xv_c;
    logic [FLIT_W-1:0] xf_c;

    // State, head register, flit counter and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next state and handshake decode
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        fifo_rd_c = 1'b0;
        req_c     = 1'b0;
        locked_c  = 1'b0;
        xv_c      = 1'b0;
        xf_c      = '0;
        unique case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    fifo_rd_c = 1'b1;
                    head_d    = bus.fifo_dout;
                    state_d   = REQ;
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (bus.grant) state_d = HEAD;
            end
            HEAD: begin
                locked_c = 1'b1;
                xv_c     = 1'b1;
                xf_c     = head_q;
                if (bus.xbar_ready) begin
                    if (PKT_FLITS == 1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BODY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            BODY: begin
                locked_c = 1'b1;
                xv_c     = !bus.fifo_empty;
                xf_c     = bus.fifo_dout;
                if (!bus.fifo_empty && bus.xbar_ready) begin
                    fifo_rd_c = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // No pops while reset is held, even though the state already reads IDLE
    assign bus.fifo_rd    = fifo_rd_c & ~rst;
    assign bus.req        = req_c;
    assign bus.head_flit  = head_q;
    assign bus.locked     = locked_c;
    assign bus.xbar_valid = xv_c;
    assign bus.xbar_flit  = xf_c;
    assign bus.pkt_done   = done_q;
endmodule

// File: tb/tb_inport_packet_requester.sv
// Scoreboard bench: the flit stream written into the FIFO model must leave on the
// crossbar in order, packet boundaries every PKT_FLITS transfers.
module tb_inport_packet_requester;
    localparam int unsigned W  = 16;
    localparam int unsigned PF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inport_packet_requester_if #(.FLIT_W(W)) bus ();

    inport_packet_requester #(.FLIT_W(W), .PKT_FLITS(PF)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // FIFO model (first-word-fall-through)
    logic [W-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic do_flush = 1'b0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_dout  = mem[rd_ptr[9:0]];

    always @(posedge clk) begin
        if (rst && do_flush) rd_ptr <= wr_ptr;
        else if (!rst && bus.fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] f);
        mem[wr_ptr[9:0]] = f;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: flit order, head presentation and pkt_done timing
    int   xfer_cnt  = 0;
    logic done_pend = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (do_flush) begin
                exp_q.delete();
                xfer_cnt  = 0;
            end
            done_pend = 1'b0;
        end else begin
            if (bus.pkt_done || done_pend) check("pkt_done", 32'(bus.pkt_done), 32'(done_pend));
            done_pend = 1'b0;
            if (bus.req) begin
                check("req_no_valid", 32'(bus.xbar_valid), 32'd0);
                if (exp_q.size() != 0) check("head_flit", 32'(bus.head_flit), 32'(exp_q[0]));
            end
            if (bus.xbar_valid && bus.xbar_ready) begin
                if (exp_q.size() == 0) check("unexpected_flit", 32'(bus.xbar_flit), 32'hFFFF_FFFF);
                else check("xbar_flit", 32'(bus.xbar_flit), 32'(exp_q.pop_front()));
                xfer_cnt++;
                if (xfer_cnt % PF == 0) done_pend = 1'b1;
            end
        end
    end

    initial begin
        int start;
        logic [W-1:0] h0;
        bool_loop: begin end
        bus.grant      = 1'b1;
        bus.xbar_ready = 1'b1;

        // Reset with a non-empty FIFO
        push(16'hA000); push(16'hA001); push(16'hA002); push(16'hA003);
        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_valid", 32'(bus.xbar_valid), 32'd0);
        check("rst_flit", 32'(bus.xbar_flit), 32'd0);
        check("rst_rd", 32'(bus.fifo_rd), 32'd0);
        check("rst_head", 32'(bus.head_flit), 32'd0);
        check("rst_done", 32'(bus.pkt_done), 32'd0);

        // Minimum-latency single packet
        start = rd_ptr;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("c0_rd", 32'(bus.fifo_rd), 32'd1);
        check("c0_req", 32'(bus.req), 32'd0);
        @(negedge clk);
        check("c1_req", 32'(bus.req), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check("cx_valid", 32'(bus.xbar_valid), 32'd1);
            check("cx_locked", 32'(bus.locked), 32'd1);
        end
        @(negedge clk);
        check("c6_done", 32'(bus.pkt_done), 32'd1);
        check("c6_locked", 32'(bus.locked), 32'd0);
        check("pop_count", 32'(rd_ptr - start), 32'd4);

        // Grant withheld for five REQ cycles
        tick();
        bus.grant = 1'b0;
        push(16'hB000); push(16'hB001); push(16'hB002); push(16'hB003);
        for (int i = 0; i < 50 && !bus.req; i++) @(negedge clk);
        check("gw_req_seen", 32'(bus.req), 32'd1);
        h0 = bus.head_flit;
        for (int i = 0; i < 5; i++) begin
            check("gw_req", 32'(bus.req), 32'd1);
            check("gw_head_stable", 32'(bus.head_flit), 32'(h0));
            check("gw_valid", 32'(bus.xbar_valid), 32'd0);
            if (i < 4) @(negedge clk);
        end
        tick();
        bus.grant = 1'b1;
        @(negedge clk);
        check("gw_req_last", 32'(bus.req), 32'd1);
        @(negedge clk);
        check("gw_head_out", 32'(bus.xbar_valid), 32'd1);
        check("gw_head_flit", 32'(bus.xbar_flit), 32'(h0));
        for (int i = 0; i < 50 && !bus.pkt_done; i++) @(negedge clk);
        check("gw_done_seen", 32'(bus.pkt_done), 32'd1);

        // Backpressure on B2
        tick();
        push(16'hC000); push(16'hC001); push(16'hC002); push(16'hC003);
        for (int i = 0; i < 50 && !(bus.xbar_valid && bus.xbar_flit == 16'hC001); i++) @(negedge clk);
        check("bp_b1_seen", 32'(bus.xbar_flit), 32'hC001);
        tick();
        bus.xbar_ready = 1'b0;
        start = rd_ptr;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", 32'(bus.xbar_flit), 32'hC002);
            check("bp_no_pop", 32'(bus.fifo_rd), 32'd0);
        end
        check("bp_ptr", 32'(rd_ptr - start), 32'd0);
        tick();
        bus.xbar_ready = 1'b1;
        for (int i = 0; i < 50 && !bus.pkt_done; i++) @(negedge clk);
        check("bp_done_seen", 32'(bus.pkt_done), 32'd1);

        // FIFO underflow mid-packet
        tick();
        push(16'hD000); push(16'hD001);
        for (int i = 0; i < 50 && !(bus.locked && !bus.xbar_valid); i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("uf_valid", 32'(bus.xbar_valid), 32'd0);
            check("uf_locked", 32'(bus.locked), 32'd1);
            @(negedge clk);
        end
        tick();
        push(16'hD002); push(16'hD003);
        for (int i = 0; i < 50 && !bus.pkt_done; i++) @(negedge clk);
        check("uf_done_seen", 32'(bus.pkt_done), 32'd1);

        // Reset in BODY with cnt=2
        tick();
        push(16'hE000); push(16'hE001); push(16'hE002); push(16'hE003);
        for (int i = 0; i < 50 && !(bus.xbar_valid && bus.xbar_flit == 16'hE001); i++) @(negedge clk);
        check("mr_b1_seen", 32'(bus.xbar_flit), 32'hE001);
        tick();
        bus.xbar_ready = 1'b0;
        tick();
        do_flush = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        check("mr_locked", 32'(bus.locked), 32'd0);
        check("mr_valid", 32'(bus.xbar_valid), 32'd0);
        check("mr_done", 32'(bus.pkt_done), 32'd0);
        tick();
        tick();
        rst      = 1'b0;
        do_flush = 1'b0;
        bus.xbar_ready = 1'b1;
        push(16'hF000); push(16'hF001); push(16'hF002); push(16'hF003);
        for (int i = 0; i < 50 && !bus.req; i++) @(negedge clk);
        check("mr_new_head", 32'(bus.head_flit), 32'hF000);
        for (int i = 0; i < 50 && !bus.pkt_done; i++) @(negedge clk);
        check("mr_done_seen", 32'(bus.pkt_done), 32'd1);

        // Randomized traffic with random grant and backpressure
        tick();
        fork
            begin
                for (int p = 0; p < 24; p++)
                    for (int f = 0; f < int'(PF); f++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        push(16'($urandom));
                    end
            end
            begin
                repeat (600) begin
                    tick();
                    bus.grant      = ($urandom_range(0, 2) != 0);
                    bus.xbar_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        tick();
        bus.grant      = 1'b1;
        bus.xbar_ready = 1'b1;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        check("final_idle_locked", 32'(bus.locked), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inport_packet_requester.md
# inport_packet_requester

Input-port requester that sits between one router input FIFO and the router's fixed-priority arbiter and crossbar. It pops a packet's head flit into a stable register and presents it to the arbiter's head-flit input. It drives the port's request line and, once the request is granted, streams the head flit and all body flits into the crossbar under a valid/ready handshake. One instance is placed per input port: IP, W, E, S, N, D, U.

## Interface
- FLIT_W, default `FLIT_BitWidth: flit width in bits.
- PKT_FLITS, default 4: flits per packet, head flit included; legal range 1..256.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  input FIFO is empty.
- fifo_dout  in  FLIT_W  input FIFO head word, first-word-fall-through.
- fifo_rd  out  1  pop strobe to the input FIFO (combinational).
- req  out  1  drives this port's bit of the arbiter `reqs` vector.
- head_flit  out  FLIT_W  registered head flit; drives this port's `*in_HeadFlit` arbiter input.
- grant  in  1  this port's bit of the arbiter `grants` vector.
- locked  out  1  packet in flight; the router freezes this port's crossbar path while it is high.
- xbar_valid  out  1  xbar_flit carries a valid flit.
- xbar_flit  out  FLIT_W  flit to the crossbar.
- xbar_ready  in  1  crossbar/output FIFO accepts the flit this cycle.
- pkt_done  out  1  one-cycle pulse after the last flit of a packet transfers.

## Operation
- FSM states: IDLE, REQ, HEAD, BODY. The state register, head register, counter (8 bits) and pkt_done are all flops.
- IDLE
  - req=0, locked=0, xbar_valid=0.
  - If fifo_empty=0: fifo_rd=1 for this cycle, head_flit <= fifo_dout, next state REQ.
- REQ
  - req=1. head_flit is held constant.
  - When grant=1 at the rising edge: next state HEAD.
  - grant=0 keeps the block in REQ indefinitely.
- HEAD
  - locked=1, xbar_valid=1, xbar_flit=head_flit.
  - On xbar_ready=1 at the edge:
    - If PKT_FLITS=1: go to IDLE and set pkt_done.
    - Otherwise: go to BODY with cnt <= 1.
- BODY
  - locked=1, xbar_valid=!fifo_empty, xbar_flit=fifo_dout, fifo_rd = xbar_valid & xbar_ready.
  - On each transfer: cnt <= cnt+1.
  - The transfer with cnt=PKT_FLITS-1 is the last one: go to IDLE and set pkt_done.
  - An empty FIFO mid-packet only stalls the block; the state is kept.
- Signal rules:
  - req is a pure decode of state REQ.
  - grant is ignored in every state other than REQ.
  - A transfer happens only when xbar_valid & xbar_ready are both high.
  - xbar_flit is don't-care when xbar_valid=0. Implementations drive 0 in IDLE/REQ.
- pkt_done is registered: high for exactly the cycle after the last transfer, otherwise 0.
- Reset, including mid-packet:
  - State goes to IDLE; head_flit, cnt and pkt_done go to 0.
  - A partially sent packet is abandoned. Already popped flits are not restored.
- Reset values: req=0, locked=0, xbar_valid=0, xbar_flit=0, fifo_rd=0, head_flit=0, pkt_done=0.

## Timing
- Minimum latency, with xbar_ready=1 and the FIFO non-empty:
  - FIFO non-empty in cycle 0: pop in cycle 0, req=1 in cycle 1.
  - Grant sampled at the end of cycle 1; head flit on the crossbar in cycle 2.
  - Body flits in cycles 3..PKT_FLITS+1.
  - pkt_done in cycle PKT_FLITS+2, the same cycle the block is back in IDLE.
- Back-to-back packets: the IDLE cycle pops the next head, so there is a 2-cycle bubble (IDLE, REQ) minimum between packets.
- Head stability: head_flit changes only in IDLE. The arbiter sees a stable address for the whole REQ wait.
- Throughput: one flit per cycle in BODY while fifo_empty=0 and xbar_ready=1.
- Combinational paths:
  - fifo_rd depends on state, fifo_empty and xbar_ready.
  - xbar_valid depends on state and fifo_empty.
  - There is no combinational path from grant to any output.

## Test plan
- Reset: hold rst=1 with a non-empty FIFO. All outputs read 0 and fifo_rd=0. Deassert rst: IDLE pops in the next cycle.
- Single packet, PKT_FLITS=4, FIFO holds H,B1,B2,B3, grant tied 1, xbar_ready=1:
  - req in cycle 1.
  - xbar_flit = H,B1,B2,B3 in cycles 2-5.
  - pkt_done in cycle 6.
  - Exactly 4 pops.
- Grant withheld 5 cycles: req stays 1 and head_flit is stable for all 5 cycles; xbar_valid=0 throughout. Grant in cycle 6: head flit on the crossbar in cycle 7.
- Backpressure: xbar_ready=0 for 3 cycles during B2. xbar_flit holds B2, no pop occurs, cnt does not change. B2 transfers when ready rises.
- FIFO underflow mid-packet: FIFO empties after B1. xbar_valid=0 and locked=1 until B2 arrives, then the packet completes normally.
- Reset asserted in BODY with cnt=2: next cycle locked=0, xbar_valid=0, pkt_done=0. The next packet's head is popped fresh after reset is released.
